// File: rtl/sap2_pkg.sv
// Shared definitions for the SAP-2 core: opcodes, FSM states and control-word layout.
package sap2_pkg;

   localparam int unsigned CW_W  = 16;
   localparam int unsigned OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPC_W-1:0] OP_STA = 4'h3;
   localparam logic [OPC_W-1:0] OP_LDI = 4'h4;
   localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
   localparam logic [OPC_W-1:0] OP_JC  = 4'h6;
   localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
   localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

   localparam int unsigned CW_EN_ALU  = 0;
   localparam int unsigned CW_SUB     = 1;
   localparam int unsigned CW_L_AR    = 2;
   localparam int unsigned CW_EN_AR   = 3;
   localparam int unsigned CW_L_OUT   = 4;
   localparam int unsigned CW_L_BR    = 5;
   localparam int unsigned CW_EN_IR   = 6;
   localparam int unsigned CW_L_IR    = 7;
   localparam int unsigned CW_EN_MEM  = 8;
   localparam int unsigned CW_L_MAR   = 9;
   localparam int unsigned CW_EN_PC   = 10;
   localparam int unsigned CW_INC_PC  = 11;
   localparam int unsigned CW_J_PC    = 12;
   localparam int unsigned CW_MEM_WE  = 13;
   localparam int unsigned CW_L_FLAGS = 14;
   localparam int unsigned CW_HLT     = 15;

   typedef enum logic [2:0] {
      F_ADDR,
      F_INC,
      F_IR,
      EX1,
      EX2,
      EX3,
      HALT
   } state_t;

endpackage

// File: rtl/sap2_ctrl.sv
// SAP-2 sequencer: state register plus combinational control-word decode.
module sap2_ctrl
   import sap2_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_mr,
   input  logic                 i_run,
   input  logic [OPC_W-1:0]     i_opcode,
   input  logic                 i_c,
   input  logic                 i_z,
   output state_t               o_state,
   output logic [CW_W-1:0]      o_cw_c
);

   state_t            r_state;
   state_t            w_next;
   logic [CW_W-1:0]   w_cw;

   always_ff @(posedge i_clk or posedge i_mr) begin
      if (i_mr) r_state <= F_ADDR;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_cw   = '0;
      case (r_state)
         F_ADDR: begin
            w_cw[CW_EN_PC] = 1'b1;
            w_cw[CW_L_MAR] = 1'b1;
            w_next         = F_INC;
         end
         F_INC: begin
            w_cw[CW_INC_PC] = 1'b1;
            w_next          = F_IR;
         end
         F_IR: begin
            w_cw[CW_EN_MEM] = 1'b1;
            w_cw[CW_L_IR]   = 1'b1;
            w_next          = EX1;
         end
         EX1: begin
            w_next = F_ADDR;
            case (i_opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  w_cw[CW_EN_IR] = 1'b1;
                  w_cw[CW_L_MAR] = 1'b1;
                  w_next         = EX2;
               end
               OP_LDI: begin
                  w_cw[CW_EN_IR] = 1'b1;
                  w_cw[CW_L_AR]  = 1'b1;
               end
               OP_JMP: begin
                  w_cw[CW_EN_IR] = 1'b1;
                  w_cw[CW_J_PC]  = 1'b1;
               end
               OP_JC: begin
                  w_cw[CW_EN_IR] = i_c;
                  w_cw[CW_J_PC]  = i_c;
               end
               OP_JZ: begin
                  w_cw[CW_EN_IR] = i_z;
                  w_cw[CW_J_PC]  = i_z;
               end
               OP_OUT: begin
                  w_cw[CW_EN_AR] = 1'b1;
                  w_cw[CW_L_OUT] = 1'b1;
               end
               OP_HLT: begin
                  w_cw[CW_HLT] = 1'b1;
                  w_next       = HALT;
               end
               default: ;
            endcase
         end
         EX2: begin
            w_next = F_ADDR;
            case (i_opcode)
               OP_LDA: begin
                  w_cw[CW_EN_MEM] = 1'b1;
                  w_cw[CW_L_AR]   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  w_cw[CW_EN_MEM] = 1'b1;
                  w_cw[CW_L_BR]   = 1'b1;
                  w_next          = EX3;
               end
               OP_STA: begin
                  w_cw[CW_EN_AR]  = 1'b1;
                  w_cw[CW_MEM_WE] = 1'b1;
               end
               default: ;
            endcase
         end
         EX3: begin
            w_cw[CW_EN_ALU]  = 1'b1;
            w_cw[CW_SUB]     = (i_opcode == OP_SUB);
            w_cw[CW_L_AR]    = 1'b1;
            w_cw[CW_L_FLAGS] = 1'b1;
            w_next           = F_ADDR;
         end
         HALT: ;
         default: w_next = F_ADDR;
      endcase
      // Hold and reset both freeze the machine; reset also kills a pending write strobe.
      if (!i_run || i_mr) begin
         w_cw   = '0;
         w_next = r_state;
      end
   end

   assign o_state = r_state;
   assign o_cw_c  = w_cw;

endmodule

// File: rtl/sap2_core.sv
// SAP-2 CPU core: datapath registers, ALU and single-driver internal bus around sap2_ctrl.
module sap2_core
   import sap2_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 mr,
   input  logic                 run,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic                 mem_we,
   output logic [DATA_W-1:0]    display,
   output logic                 halted,
   output logic [DATA_W-1:0]    debug_bus,
   output logic [CW_W-1:0]      debug_cw
);

   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_mar;
   logic [OPC_W-1:0]   r_opc;
   logic [ADDR_W-1:0]  r_opnd;
   logic [DATA_W-1:0]  r_a;
   logic [DATA_W-1:0]  r_b;
   logic [DATA_W-1:0]  r_out;
   logic               r_c;
   logic               r_z;

   logic [CW_W-1:0]    w_cw;
   state_t             w_state;
   logic [DATA_W-1:0]  w_bus;
   logic [DATA_W-1:0]  w_b_op;
   logic [DATA_W:0]    w_alu;

   sap2_ctrl u_ctrl (
      .i_clk    (clk),
      .i_mr     (mr),
      .i_run    (run),
      .i_opcode (r_opc),
      .i_c      (r_c),
      .i_z      (r_z),
      .o_state  (w_state),
      .o_cw_c   (w_cw)
   );

   // Subtract is A + ~B + 1, so carry-out means "no borrow".
   assign w_b_op = w_cw[CW_SUB] ? ~r_b : r_b;
   assign w_alu  = {1'b0, r_a} + {1'b0, w_b_op} + (DATA_W+1)'(w_cw[CW_SUB]);

   always_comb begin
      w_bus = '0;
      if      (w_cw[CW_EN_PC])  w_bus = DATA_W'(r_pc);
      else if (w_cw[CW_EN_IR])  w_bus = DATA_W'(r_opnd);
      else if (w_cw[CW_EN_MEM]) w_bus = mem_rdata;
      else if (w_cw[CW_EN_AR])  w_bus = r_a;
      else if (w_cw[CW_EN_ALU]) w_bus = w_alu[DATA_W-1:0];
   end

   always_ff @(posedge clk or posedge mr) begin
      if (mr) begin
         r_pc   <= '0;
         r_mar  <= '0;
         r_opc  <= '0;
         r_opnd <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_out  <= '0;
         r_c    <= 1'b0;
         r_z    <= 1'b0;
      end else begin
         if (w_cw[CW_INC_PC])     r_pc  <= r_pc + ADDR_W'(1);
         else if (w_cw[CW_J_PC])  r_pc  <= w_bus[ADDR_W-1:0];
         if (w_cw[CW_L_MAR])      r_mar <= w_bus[ADDR_W-1:0];
         if (w_cw[CW_L_IR]) begin
            r_opc  <= w_bus[DATA_W-1 -: OPC_W];
            r_opnd <= w_bus[ADDR_W-1:0];
         end
         if (w_cw[CW_L_AR])       r_a   <= w_bus;
         if (w_cw[CW_L_BR])       r_b   <= w_bus;
         if (w_cw[CW_L_OUT])      r_out <= w_bus;
         if (w_cw[CW_L_FLAGS]) begin
            r_c <= w_alu[DATA_W];
            r_z <= (w_alu[DATA_W-1:0] == '0);
         end
      end
   end

   assign mem_addr  = r_mar;
   assign mem_wdata = r_a;
   assign mem_we    = w_cw[CW_MEM_WE];
   assign display   = r_out;
   assign halted    = (w_state == HALT);
   assign debug_bus = w_bus;
   assign debug_cw  = w_cw;

endmodule

// File: tb/tb_sap2_core.sv
// Directed and random-program bench for sap2_core against an instruction-level model.
module tb_sap2_core;
   import sap2_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned NW = 16;

   logic           clk = 1'b0;
   logic           mr  = 1'b1;
   logic           run = 1'b1;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_rdata;
   logic [DW-1:0]  mem_wdata;
   logic           mem_we;
   logic [DW-1:0]  display;
   logic           halted;
   logic [DW-1:0]  debug_bus;
   logic [15:0]    debug_cw;

   logic [7:0]     ram [NW];
   logic [7:0]     img [NW];
   logic           ld_en = 1'b0;
   int             wr_count;
   logic [3:0]     wr_addr;
   logic [7:0]     wr_data;

   int checks = 0;
   int errors = 0;

   // instruction-level model state
   int m_pc, m_a, m_c, m_z, m_out, m_halt;
   int rmem [NW];

   sap2_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .mr        (mr),
      .run       (run),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .display   (display),
      .halted    (halted),
      .debug_bus (debug_bus),
      .debug_cw  (debug_cw)
   );

   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr];

   always @(posedge clk) begin
      if (ld_en) begin
         for (int i = 0; i < NW; i++) ram[i] <= img[i];
         wr_count <= 0;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
         wr_count      <= wr_count + 1;
         wr_addr       <= mem_addr;
         wr_data       <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, ".addr"},  32'(mem_addr),  32'h0);
      chk({tag, ".wdata"}, 32'(mem_wdata), 32'h0);
      chk({tag, ".we"},    32'(mem_we),    32'h0);
      chk({tag, ".disp"},  32'(display),   32'h0);
      chk({tag, ".halt"},  32'(halted),    32'h0);
      chk({tag, ".bus"},   32'(debug_bus), 32'h0);
      chk({tag, ".cw"},    32'(debug_cw),  32'h0);
   endtask

   task automatic clr_img();
      for (int i = 0; i < NW; i++) img[i] = 8'h00;
   endtask

   // Loads img into RAM while the core sits in reset, then releases reset mid-cycle.
   task automatic load_reset(input string tag);
      mr    = 1'b1;
      run   = 1'b1;
      ld_en = 1'b1;
      @(posedge clk);
      #1;
      ld_en = 1'b0;
      chk_cleared(tag);
      mr = 1'b0;
   endtask

   task automatic model_step(output int cyc);
      int ins, op, opnd, s;
      ins  = rmem[m_pc];
      m_pc = (m_pc + 1) % NW;
      op   = ins / 16;
      opnd = ins % 16;
      cyc  = 4;
      case (op)
         0: begin m_a = rmem[opnd]; cyc = 5; end
         1: begin
            s = m_a + rmem[opnd];
            m_c = (s > 255) ? 1 : 0;
            m_a = s % 256;
            m_z = (m_a == 0) ? 1 : 0;
            cyc = 6;
         end
         2: begin
            s = m_a - rmem[opnd];
            m_c = (s >= 0) ? 1 : 0;
            m_a = (s + 256) % 256;
            m_z = (m_a == 0) ? 1 : 0;
            cyc = 6;
         end
         3: begin rmem[opnd] = m_a; cyc = 5; end
         4: m_a = opnd;
         5: m_pc = opnd;
         6: if (m_c != 0) m_pc = opnd;
         7: if (m_z != 0) m_pc = opnd;
         14: m_out = m_a;
         15: m_halt = 1;
         default: ;
      endcase
   endtask

   initial begin
      int cyc;

      // LDA 9; ADD A; OUT; HLT
      clr_img();
      img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'hE0; img[3] = 8'hF0;
      img[9] = 8'h1C; img[10] = 8'h0E;
      load_reset("rst");
      tick(18);
      chk("add.pre_halt", 32'(halted), 32'h0);
      tick(1);
      chk("add.halted", 32'(halted), 32'h1);
      chk("add.display", 32'(display), 32'h2A);
      chk("add.acc", 32'(mem_wdata), 32'h2A);
      run = 1'b0;
      tick(2);
      run = 1'b1;
      tick(3);
      chk("halt.hold_disp", 32'(display), 32'h2A);
      chk("halt.hold_flag", 32'(halted), 32'h1);
      chk("halt.cw", 32'(debug_cw), 32'h0);

      // LDI 5; SUB 5; JC 8; (8) JZ 0
      clr_img();
      img[0] = 8'h45; img[1] = 8'h25; img[2] = 8'h68; img[5] = 8'h05; img[8] = 8'h70;
      load_reset("rst2");
      tick(10);
      chk("sub.acc", 32'(mem_wdata), 32'h0);
      tick(4);
      chk("sub.jc_pc", 32'(debug_bus), 32'h8);
      tick(4);
      chk("sub.jz_pc", 32'(debug_bus), 32'h0);
      chk("sub.fetch_cw", 32'(debug_cw), 32'h0600);

      // LDI 3; STA F; LDA F
      clr_img();
      img[0] = 8'h43; img[1] = 8'h3F; img[2] = 8'h0F; img[3] = 8'hF0;
      load_reset("rst3");
      tick(8);
      chk("sta.we", 32'(mem_we), 32'h1);
      chk("sta.addr", 32'(mem_addr), 32'hF);
      chk("sta.wdata", 32'(mem_wdata), 32'h3);
      tick(1);
      chk("sta.we_drop", 32'(mem_we), 32'h0);
      tick(5);
      chk("sta.count", 32'(wr_count), 32'h1);
      chk("sta.waddr", 32'(wr_addr), 32'hF);
      chk("sta.wdat", 32'(wr_data), 32'h3);
      chk("sta.lda", 32'(mem_wdata), 32'h3);

      // JMP B; (B) LDA 1; ADD 2; JC F; HLT; (F) OUT -> wraps to 0
      clr_img();
      img[0] = 8'h5B; img[1] = 8'hFF; img[2] = 8'h01;
      img[11] = 8'h01; img[12] = 8'h12; img[13] = 8'h6F; img[14] = 8'hF0; img[15] = 8'hE0;
      load_reset("rst4");
      tick(4);
      chk("wrap.jmp", 32'(debug_bus), 32'hB);
      tick(5);
      chk("wrap.lda", 32'(mem_wdata), 32'hFF);
      tick(6);
      chk("wrap.add", 32'(mem_wdata), 32'h0);
      tick(4);
      chk("wrap.jc", 32'(debug_bus), 32'hF);
      chk("wrap.nohalt", 32'(halted), 32'h0);
      tick(4);
      chk("wrap.pc0", 32'(debug_bus), 32'h0);
      tick(4);
      chk("wrap.again", 32'(debug_bus), 32'hB);

      // run=0 while STA sits in EX2
      clr_img();
      img[0] = 8'h47; img[1] = 8'h3E; img[2] = 8'hF0;
      load_reset("rst5");
      tick(8);
      chk("hold.we_pre", 32'(mem_we), 32'h1);
      run = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("hold.we", 32'(mem_we), 32'h0);
         chk("hold.cw", 32'(debug_cw), 32'h0);
         tick(1);
         chk("hold.count", 32'(wr_count), 32'h0);
      end
      run = 1'b1;
      #1;
      chk("hold.we_back", 32'(mem_we), 32'h1);
      chk("hold.addr", 32'(mem_addr), 32'hE);
      tick(1);
      chk("hold.count1", 32'(wr_count), 32'h1);
      chk("hold.ram", 32'(ram[14]), 32'h07);
      tick(4);
      chk("hold.halt", 32'(halted), 32'h1);

      // mr asserted during ADD EX2
      clr_img();
      img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'hE0; img[3] = 8'hF0;
      img[9] = 8'h1C; img[10] = 8'h0E;
      load_reset("rst6");
      tick(9);
      chk("abort.in_ex2", 32'(debug_cw), 32'h0120);
      mr = 1'b1;
      #1;
      chk_cleared("abort");
      @(posedge clk);
      #1;
      mr = 1'b0;
      #1;
      chk("abort.restart_cw", 32'(debug_cw), 32'h0600);
      chk("abort.restart_pc", 32'(debug_bus), 32'h0);
      tick(19);
      chk("abort.halt", 32'(halted), 32'h1);
      chk("abort.display", 32'(display), 32'h2A);

      // random programs against the instruction-level model
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < NW; i++) begin
            img[i] = 8'($urandom);
            if (img[i][7:4] == 4'hF && $urandom_range(0, 3) != 0)
               img[i][7:4] = 4'($urandom_range(0, 7));
            rmem[i] = int'(img[i]);
         end
         m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_out = 0; m_halt = 0;
         load_reset("rnd.rst");
         for (int k = 0; k < 40 && m_halt == 0; k++) begin
            model_step(cyc);
            tick(cyc);
            chk("rnd.pc", 32'(debug_bus), (m_halt != 0) ? 32'h0 : 32'(m_pc));
            chk("rnd.acc", 32'(mem_wdata), 32'(m_a));
            chk("rnd.disp", 32'(display), 32'(m_out));
            chk("rnd.halt", 32'(halted), 32'(m_halt));
         end
         for (int i = 0; i < NW; i++) chk("rnd.mem", 32'(ram[i]), 32'(rmem[i]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
